// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: rectangle compositing modes and the
// per-rectangle configuration record held in the shadow and active banks.
package vga_pkg;
  localparam int VGA_WIDTHBITS  = 10;
  localparam int VGA_HEIGHTBITS = 10;
  localparam int VGA_COLORBITS  = 8;

  localparam logic [1:0] RECT_MODE_OR      = 2'b00;
  localparam logic [1:0] RECT_MODE_REPLACE = 2'b01;
  localparam logic [1:0] RECT_MODE_XOR     = 2'b10;
  localparam logic [1:0] RECT_MODE_RSVD    = 2'b11;

  typedef struct packed {
    logic                      enabled;
    logic [1:0]                mode;
    logic [VGA_COLORBITS-1:0]  color;
    logic [VGA_WIDTHBITS-1:0]  x1;
    logic [VGA_HEIGHTBITS-1:0] y1;
    logic [VGA_WIDTHBITS-1:0]  x2;
    logic [VGA_HEIGHTBITS-1:0] y2;
  } rect_cfg_t;
endpackage

// File: rtl/vga_rect_hit.sv
// Bound test for one rectangle; reserved mode or inverted bounds never hit.
module vga_rect_hit
  import vga_pkg::*;
(
  input  rect_cfg_t                 rect,
  input  logic [VGA_WIDTHBITS-1:0]  x,
  input  logic [VGA_HEIGHTBITS-1:0] y,
  output logic                      hit
);
  assign hit = rect.enabled && (rect.mode != RECT_MODE_RSVD) &&
               (x >= rect.x1) && (x <= rect.x2) &&
               (y >= rect.y1) && (y <= rect.y2);
endmodule

// File: rtl/vga_stage_rect_multi.sv
// Multi-rectangle overlay stage: double-buffered rectangle set, hit vector in
// stage 1, index-ordered compositing fold in stage 2.
module vga_stage_rect_multi
  import vga_pkg::*;
#(
  parameter int WIDTHBITS  = VGA_WIDTHBITS,
  parameter int HEIGHTBITS = VGA_HEIGHTBITS,
  parameter int COLORBITS  = VGA_COLORBITS,
  parameter int MULTIBITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [COLORBITS-1:0]  st__color_0a,
  input  logic [WIDTHBITS-1:0]  st__x_0a,
  input  logic [HEIGHTBITS-1:0] st__y_0a,
  output logic [COLORBITS-1:0]  st__color_2a,
  output logic [WIDTHBITS-1:0]  st__x_2a,
  output logic [HEIGHTBITS-1:0] st__y_2a,
  input  logic                  vg__stall,
  input  logic                  vg__vblank,
  input  logic                  vg__rect_write,
  input  logic [MULTIBITS-1:0]  st__conf_multi_index,
  input  logic                  st__conf_enabled,
  input  logic [1:0]            st__conf_mode,
  input  logic [COLORBITS-1:0]  st__conf_color,
  input  logic [WIDTHBITS-1:0]  st__conf_rect_x1,
  input  logic [WIDTHBITS-1:0]  st__conf_rect_x2,
  input  logic [HEIGHTBITS-1:0] st__conf_rect_y1,
  input  logic [HEIGHTBITS-1:0] st__conf_rect_y2,
  input  logic                  vg__commit,
  output logic                  st__commit_pending,
  output logic                  st__commit_done
);
  localparam int NRECT = 2**MULTIBITS;

  rect_cfg_t shadow [NRECT];
  rect_cfg_t active [NRECT];
  logic      swap;

  assign swap = st__commit_pending && vg__vblank;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < NRECT; i++) begin
        shadow[i].enabled <= 1'b0;
        shadow[i].mode    <= RECT_MODE_OR;
      end
    end else if (vg__rect_write) begin
      shadow[st__conf_multi_index] <= '{enabled: st__conf_enabled, mode: st__conf_mode,
                                        color: st__conf_color,
                                        x1: st__conf_rect_x1, y1: st__conf_rect_y1,
                                        x2: st__conf_rect_x2, y2: st__conf_rect_y2};
    end
  end

  // Swap copies pre-edge shadow, so a coincident write reaches shadow only.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < NRECT; i++) begin
        active[i].enabled <= 1'b0;
        active[i].mode    <= RECT_MODE_OR;
      end
    end else if (swap) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      st__commit_pending <= 1'b0;
      st__commit_done    <= 1'b0;
    end else begin
      st__commit_done <= swap;
      if (swap) st__commit_pending <= vg__commit;
      else if (vg__commit) st__commit_pending <= 1'b1;
    end
  end

  logic [NRECT-1:0]      hit_0a, hit_1a;
  logic [COLORBITS-1:0]  color_1a;
  logic [WIDTHBITS-1:0]  x_1a;
  logic [HEIGHTBITS-1:0] y_1a;
  logic [COLORBITS-1:0]  acc [NRECT+1];

  assign acc[0] = color_1a;

  for (genvar i = 0; i < NRECT; i++) begin : g_rect
    vga_rect_hit u_hit (
      .rect (active[i]),
      .x    (st__x_0a),
      .y    (st__y_0a),
      .hit  (hit_0a[i])
    );
    assign acc[i+1] = !hit_1a[i]                         ? acc[i] :
                      active[i].mode == RECT_MODE_OR      ? acc[i] | active[i].color :
                      active[i].mode == RECT_MODE_REPLACE ? active[i].color :
                      active[i].mode == RECT_MODE_XOR     ? acc[i] ^ active[i].color :
                                                            acc[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_1a       <= '0;
      color_1a     <= '0;
      x_1a         <= '0;
      y_1a         <= '0;
      st__color_2a <= '0;
      st__x_2a     <= '0;
      st__y_2a     <= '0;
    end else if (!vg__stall) begin
      hit_1a       <= hit_0a;
      color_1a     <= st__color_0a;
      x_1a         <= st__x_0a;
      y_1a         <= st__y_0a;
      st__color_2a <= acc[NRECT];
      st__x_2a     <= x_1a;
      st__y_2a     <= y_1a;
    end
  end
endmodule

// File: tb/tb_vga_stage_rect_multi.sv
// Directed bench for the multi-rectangle overlay stage.
module tb_vga_stage_rect_multi;
  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] st__color_0a, st__color_2a;
  logic [9:0] st__x_0a, st__x_2a, st__y_0a, st__y_2a;
  logic       vg__stall, vg__vblank, vg__rect_write, vg__commit;
  logic [4:0] st__conf_multi_index;
  logic       st__conf_enabled;
  logic [1:0] st__conf_mode;
  logic [7:0] st__conf_color;
  logic [9:0] st__conf_rect_x1, st__conf_rect_x2, st__conf_rect_y1, st__conf_rect_y2;
  logic       st__commit_pending, st__commit_done;

  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  vga_stage_rect_multi dut (
    .clk(clk), .rst_b(rst_b),
    .st__color_0a(st__color_0a), .st__x_0a(st__x_0a), .st__y_0a(st__y_0a),
    .st__color_2a(st__color_2a), .st__x_2a(st__x_2a), .st__y_2a(st__y_2a),
    .vg__stall(vg__stall), .vg__vblank(vg__vblank), .vg__rect_write(vg__rect_write),
    .st__conf_multi_index(st__conf_multi_index), .st__conf_enabled(st__conf_enabled),
    .st__conf_mode(st__conf_mode), .st__conf_color(st__conf_color),
    .st__conf_rect_x1(st__conf_rect_x1), .st__conf_rect_x2(st__conf_rect_x2),
    .st__conf_rect_y1(st__conf_rect_y1), .st__conf_rect_y2(st__conf_rect_y2),
    .vg__commit(vg__commit), .st__commit_pending(st__commit_pending),
    .st__commit_done(st__commit_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_conf(input int idx, input int en, input int mode, input int col,
                          input int x1, input int y1, input int x2, input int y2);
    st__conf_multi_index = 5'(idx);
    st__conf_enabled     = 1'(en);
    st__conf_mode        = 2'(mode);
    st__conf_color       = 8'(col);
    st__conf_rect_x1     = 10'(x1);
    st__conf_rect_y1     = 10'(y1);
    st__conf_rect_x2     = 10'(x2);
    st__conf_rect_y2     = 10'(y2);
  endtask

  task automatic wr(input int idx, input int en, input int mode, input int col,
                    input int x1, input int y1, input int x2, input int y2);
    set_conf(idx, en, mode, col, x1, y1, x2, y2);
    vg__rect_write = 1'b1;
    tick();
    vg__rect_write = 1'b0;
  endtask

  task automatic commit_and_swap();
    vg__commit = 1'b1;
    tick();
    vg__commit = 1'b0;
    vg__vblank = 1'b1;
    tick();
    vg__vblank = 1'b0;
  endtask

  task automatic pix(input int c, input int x, input int y);
    st__color_0a = 8'(c);
    st__x_0a     = 10'(x);
    st__y_0a     = 10'(y);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    st__color_0a = 8'h77; st__x_0a = 10'd3; st__y_0a = 10'd4;
    tick(); tick();
    cmps++; if (st__color_2a !== 8'h00) begin errs++; $display("FAIL reset_color got %h want 00", st__color_2a); end
    cmps++; if (st__x_2a !== 10'd0 || st__y_2a !== 10'd0) begin errs++; $display("FAIL reset_xy got %0d,%0d want 0,0", st__x_2a, st__y_2a); end
    cmps++; if (st__commit_pending !== 1'b0 || st__commit_done !== 1'b0) begin errs++; $display("FAIL reset_commit got p=%b d=%b want 0 0", st__commit_pending, st__commit_done); end
    rst_b = 1'b1;
  endtask

  task automatic test_passthrough();
    pix(8'h5A, 10, 10);
    cmps++; if (st__color_2a !== 8'h5A) begin errs++; $display("FAIL pass_color got %h want 5a", st__color_2a); end
    cmps++; if (st__x_2a !== 10'd10 || st__y_2a !== 10'd10) begin errs++; $display("FAIL pass_xy got %0d,%0d want 10,10", st__x_2a, st__y_2a); end
    cmps++; if (st__commit_pending !== 1'b0) begin errs++; $display("FAIL pass_pending got %b want 0", st__commit_pending); end
  endtask

  task automatic test_commit_or();
    wr(0, 1, 0, 8'h0F, 0, 0, 20, 20);
    vg__commit = 1'b1;
    tick();
    vg__commit = 1'b0;
    cmps++; if (st__commit_pending !== 1'b1) begin errs++; $display("FAIL or_pending got %b want 1", st__commit_pending); end
    vg__vblank = 1'b1;
    tick();
    vg__vblank = 1'b0;
    cmps++; if (st__commit_done !== 1'b1 || st__commit_pending !== 1'b0) begin errs++; $display("FAIL or_done got d=%b p=%b want 1 0", st__commit_done, st__commit_pending); end
    tick();
    cmps++; if (st__commit_done !== 1'b0) begin errs++; $display("FAIL or_done_pulse got %b want 0", st__commit_done); end
    pix(8'hA0, 20, 20);
    cmps++; if (st__color_2a !== 8'hAF) begin errs++; $display("FAIL or_inside got %h want af", st__color_2a); end
    pix(8'hA0, 21, 20);
    cmps++; if (st__color_2a !== 8'hA0) begin errs++; $display("FAIL or_outside got %h want a0", st__color_2a); end
  endtask

  task automatic test_order();
    wr(1, 1, 1, 8'h33, 0, 0, 10, 10);
    wr(2, 1, 2, 8'hFF, 5, 5, 5, 5);
    commit_and_swap();
    pix(8'h80, 5, 5);
    cmps++; if (st__color_2a !== 8'hCC) begin errs++; $display("FAIL order_3hit got %h want cc", st__color_2a); end
    pix(8'h80, 6, 6);
    cmps++; if (st__color_2a !== 8'h33) begin errs++; $display("FAIL order_2hit got %h want 33", st__color_2a); end
  endtask

  task automatic test_no_commit();
    wr(4, 1, 1, 8'h11, 30, 30, 30, 30);
    wr(3, 1, 3, 8'hFF, 6, 6, 6, 6);
    wr(5, 1, 1, 8'h77, 50, 0, 40, 100);
    pix(8'h44, 30, 30);
    cmps++; if (st__color_2a !== 8'h44) begin errs++; $display("FAIL shadow_only got %h want 44", st__color_2a); end
    vg__commit = 1'b1;
    tick();
    vg__commit = 1'b0;
    pix(8'h44, 30, 30);
    cmps++; if (st__color_2a !== 8'h44) begin errs++; $display("FAIL no_vblank got %h want 44", st__color_2a); end
    cmps++; if (st__commit_pending !== 1'b1) begin errs++; $display("FAIL no_vblank_pending got %b want 1", st__commit_pending); end
    vg__vblank = 1'b1;
    tick();
    vg__vblank = 1'b0;
    pix(8'h44, 30, 30);
    cmps++; if (st__color_2a !== 8'h11) begin errs++; $display("FAIL late_swap got %h want 11", st__color_2a); end
    pix(8'h80, 6, 6);
    cmps++; if (st__color_2a !== 8'h33) begin errs++; $display("FAIL rsvd_mode got %h want 33", st__color_2a); end
    pix(8'h12, 45, 45);
    cmps++; if (st__color_2a !== 8'h12) begin errs++; $display("FAIL inverted_bounds got %h want 12", st__color_2a); end
  endtask

  task automatic test_stall();
    st__color_0a = 8'hB0; st__x_0a = 10'd100; st__y_0a = 10'd200; tick();
    st__color_0a = 8'hB1; st__x_0a = 10'd101; tick();
    cmps++; if (st__color_2a !== 8'hB0 || st__x_2a !== 10'd100) begin errs++; $display("FAIL stall_pre got %h@%0d want b0@100", st__color_2a, st__x_2a); end
    st__color_0a = 8'hB2; st__x_0a = 10'd102;
    vg__stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmps++; if (st__color_2a !== 8'hB0 || st__x_2a !== 10'd100) begin errs++; $display("FAIL stall_hold%0d got %h@%0d want b0@100", i, st__color_2a, st__x_2a); end
    end
    vg__stall = 1'b0;
    tick();
    cmps++; if (st__color_2a !== 8'hB1 || st__x_2a !== 10'd101) begin errs++; $display("FAIL stall_resume1 got %h@%0d want b1@101", st__color_2a, st__x_2a); end
    st__color_0a = 8'hB3; st__x_0a = 10'd103; tick();
    cmps++; if (st__color_2a !== 8'hB2 || st__x_2a !== 10'd102) begin errs++; $display("FAIL stall_resume2 got %h@%0d want b2@102", st__color_2a, st__x_2a); end
    tick();
    cmps++; if (st__color_2a !== 8'hB3 || st__x_2a !== 10'd103) begin errs++; $display("FAIL stall_resume3 got %h@%0d want b3@103", st__color_2a, st__x_2a); end
  endtask

  task automatic test_coincident();
    wr(6, 1, 1, 8'h66, 60, 60, 60, 60);
    vg__commit = 1'b1;
    tick();
    set_conf(3, 1, 1, 8'h99, 70, 70, 70, 70);
    vg__rect_write = 1'b1;
    vg__vblank = 1'b1;
    tick();
    vg__rect_write = 1'b0; vg__vblank = 1'b0; vg__commit = 1'b0;
    cmps++; if (st__commit_pending !== 1'b1 || st__commit_done !== 1'b1) begin errs++; $display("FAIL coinc_flags got p=%b d=%b want 1 1", st__commit_pending, st__commit_done); end
    pix(8'h01, 60, 60);
    cmps++; if (st__color_2a !== 8'h66) begin errs++; $display("FAIL coinc_swapped got %h want 66", st__color_2a); end
    pix(8'h01, 70, 70);
    cmps++; if (st__color_2a !== 8'h01) begin errs++; $display("FAIL coinc_old3 got %h want 01", st__color_2a); end
    cmps++; if (st__commit_pending !== 1'b1) begin errs++; $display("FAIL coinc_armed got %b want 1", st__commit_pending); end
    vg__vblank = 1'b1;
    tick();
    vg__vblank = 1'b0;
    cmps++; if (st__commit_pending !== 1'b0) begin errs++; $display("FAIL coinc_cleared got %b want 0", st__commit_pending); end
    pix(8'h01, 70, 70);
    cmps++; if (st__color_2a !== 8'h99) begin errs++; $display("FAIL coinc_new3 got %h want 99", st__color_2a); end
  endtask

  initial begin
    rst_b = 1'b0;
    vg__stall = 1'b0; vg__vblank = 1'b0; vg__rect_write = 1'b0; vg__commit = 1'b0;
    set_conf(0, 0, 0, 0, 0, 0, 0, 0);
    st__color_0a = '0; st__x_0a = '0; st__y_0a = '0;
    #2;
    test_reset();
    test_passthrough();
    test_commit_or();
    test_order();
    test_no_commit();
    test_stall();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
